// File: rtl/dcache_pkg.sv
// Shared types, geometry and address field helpers for the L1 data cache.
package dcache_pkg;

    localparam int LINES     = 32;
    localparam int LINE_BITS = 256;
    localparam int ADDR_W    = 32;
    localparam int OFF_W     = 5;
    localparam int IDX_W     = $clog2(LINES);
    localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;
    localparam int WORDS     = LINE_BITS / 32;
    localparam int WSEL_W    = $clog2(WORDS);

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [IDX_W-1:0]     idx_t;
    typedef logic [WSEL_W-1:0]    wsel_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    function automatic tag_t get_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic idx_t get_index(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    function automatic wsel_t get_word(input logic [ADDR_W-1:0] addr);
        return addr[2 +: WSEL_W];
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Valid/dirty/tag/data storage for the direct-mapped data cache.
// Reads are asynchronous at the requested index; writes land on the clock edge.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  idx_t  idx_i,
    input  logic  fill_en_i,
    input  tag_t  fill_tag_i,
    input  line_t fill_line_i,
    input  logic  word_en_i,
    input  wsel_t word_sel_i,
    input  logic [31:0] word_data_i,
    output logic  valid_o,
    output logic  dirty_o,
    output tag_t  tag_o,
    output line_t line_o
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    tag_t             tag_q  [LINES];
    line_t            data_q [LINES];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    // Status bits: a refill makes the line clean and valid, a store marks it dirty.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_en_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data payload; contents are meaningless until valid is set, so no reset.
    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (word_en_i) begin
            data_q[idx_i][{word_sel_i, 5'b00000} +: 32] <= word_data_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage L1 data cache controller: direct-mapped, write-back, write-allocate.
// Hits complete with zero latency; misses freeze the pipeline while the victim
// is written back (if dirty) and the new line is fetched.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         MemRead_i,
    input  logic         MemWrite_i,
    input  logic [31:0]  addr_i,
    input  logic [31:0]  wdata_i,
    output logic [31:0]  rdata_o,
    output logic         stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    state_t state_q, state_d;

    tag_t  req_tag;
    idx_t  req_idx;
    wsel_t req_word;

    logic  line_valid;
    logic  line_dirty;
    tag_t  line_tag;
    line_t line_data;

    logic  req;
    logic  hit;
    logic  fill_en;
    logic  word_en;

    assign req_tag  = get_tag(addr_i);
    assign req_idx  = get_index(addr_i);
    assign req_word = get_word(addr_i);

    assign req = MemRead_i | MemWrite_i;
    assign hit = req & line_valid & (line_tag == req_tag);

    dcache_sram u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (req_idx),
        .fill_en_i   (fill_en),
        .fill_tag_i  (req_tag),
        .fill_line_i (mem_data_i),
        .word_en_i   (word_en),
        .word_sel_i  (req_word),
        .word_data_i (wdata_i),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .tag_o       (line_tag),
        .line_o      (line_data)
    );

    // Miss-handling state register; reset abandons any memory transaction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all outputs; everything is forced quiet while reset is asserted.
    always_comb begin
        state_d      = state_q;
        rdata_o      = '0;
        stall_o      = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        fill_en      = 1'b0;
        word_en      = 1'b0;
        if (rst_i) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (MemWrite_i) begin
                                word_en = 1'b1;
                            end else begin
                                rdata_o = line_data[{req_word, 5'b00000} +: 32];
                            end
                        end else begin
                            stall_o = 1'b1;
                            state_d = (line_valid & line_dirty) ? WRITEBACK : ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    stall_o      = req;
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = {line_tag, req_idx, {OFF_W{1'b0}}};
                    mem_data_o   = line_data;
                    if (mem_ack_i) begin
                        state_d = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    stall_o      = req;
                    mem_enable_o = 1'b1;
                    mem_addr_o   = {req_tag, req_idx, {OFF_W{1'b0}}};
                    if (mem_ack_i) begin
                        fill_en = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold fill, write hit, dirty and clean
// evictions, stray memory ack, and reset in the middle of a refill.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int LAT = 10;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         MemRead_i;
    logic         MemWrite_i;
    logic [31:0]  addr_i;
    logic [31:0]  wdata_i;
    logic [31:0]  rdata_o;
    logic         stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int checkCount  = 0;
    int errorCount  = 0;
    int stallCycles = 0;

    line_t lineA;
    line_t lineB;
    line_t lineC;

    always #5 clk_i = ~clk_i;

    dcache_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .stall_o      (stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        MemRead_i  = rd;
        MemWrite_i = wr;
        addr_i     = addr;
        wdata_i    = data;
    endtask

    function automatic line_t makeLine(input logic [31:0] base);
        line_t l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = base + 32'(w);
        end
        return l;
    endfunction

    // One memory transaction lasting LAT cycles, acked on the last one.
    task automatic memPhase(input string name, input logic expWrite, input logic [31:0] expAddr,
                            input line_t fill, input int wbWord, input logic [31:0] wbVal);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            #1;
            if (stall_o) stallCycles++;
            if (c == 1) begin
                checkOutput({name, " enable"}, {31'b0, mem_enable_o}, 32'd1);
                checkOutput({name, " write"}, {31'b0, mem_write_o}, {31'b0, expWrite});
                checkOutput({name, " addr"}, mem_addr_o, expAddr);
                if (expWrite) begin
                    checkOutput({name, " wb word"}, mem_data_o[wbWord*32 +: 32], wbVal);
                end
            end
            if (c == LAT) begin
                checkOutput({name, " addr held"}, mem_addr_o, expAddr);
                mem_data_i = fill;
                mem_ack_i  = 1'b1;
            end
        end
    endtask

    initial begin
        rst_i      = 1'b0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        lineA = makeLine(32'hA000_0000);
        lineA[2*32 +: 32] = 32'hDEAD_BEEF;
        lineB = makeLine(32'hB000_0000);
        lineC = makeLine(32'hC000_0000);

        // Reset state
        #1;
        checkOutput("reset stall", {31'b0, stall_o}, 32'd0);
        checkOutput("reset enable", {31'b0, mem_enable_o}, 32'd0);
        checkOutput("reset mem_addr", mem_addr_o, 32'h0);
        checkOutput("reset rdata", rdata_o, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Cold read miss on 0x40, then 0x48 from the filled line
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        #1;
        checkOutput("cold stall idle", {31'b0, stall_o}, 32'd1);
        checkOutput("cold enable idle", {31'b0, mem_enable_o}, 32'd0);
        stallCycles = 1;
        memPhase("cold fill", 1'b0, 32'h0000_0040, lineA, 0, 32'h0);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0000_0048, 32'h0);
        #1;
        checkOutput("cold hit stall", {31'b0, stall_o}, 32'd0);
        checkOutput("cold hit rdata", rdata_o, 32'hDEAD_BEEF);
        checkOutput("cold stall cycles", 32'(stallCycles), 32'd11);
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        #1;
        checkOutput("read word0", rdata_o, 32'hA000_0000);

        // Write hit to 0x44
        @(negedge clk_i);
        applyStimulus(1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678);
        #1;
        checkOutput("write hit stall", {31'b0, stall_o}, 32'd0);
        checkOutput("write hit enable", {31'b0, mem_enable_o}, 32'd0);
        checkOutput("write hit rdata", rdata_o, 32'h0);
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        #1;
        checkOutput("read after write", rdata_o, 32'h1234_5678);
        checkOutput("read after write stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 32'h0000_0048, 32'h0);
        #1;
        checkOutput("neighbour word", rdata_o, 32'hDEAD_BEEF);

        // Dirty eviction: 0x444 maps to index 2 with tag 1
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 32'h0000_0444, 32'h0);
        #1;
        checkOutput("dirty miss stall", {31'b0, stall_o}, 32'd1);
        stallCycles = 1;
        memPhase("evict wb", 1'b1, 32'h0000_0040, lineB, 1, 32'h1234_5678);
        memPhase("evict fill", 1'b0, 32'h0000_0440, lineB, 0, 32'h0);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        checkOutput("evict hit stall", {31'b0, stall_o}, 32'd0);
        checkOutput("evict hit rdata", rdata_o, 32'hB000_0001);
        checkOutput("dirty stall cycles", 32'(stallCycles), 32'd21);

        // Clean eviction: 0x848 is index 2 with tag 2, no write-back expected
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 32'h0000_0848, 32'h0);
        #1;
        checkOutput("clean miss stall", {31'b0, stall_o}, 32'd1);
        stallCycles = 1;
        memPhase("clean fill", 1'b0, 32'h0000_0840, lineC, 0, 32'h0);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        checkOutput("clean hit rdata", rdata_o, 32'hC000_0002);
        checkOutput("clean stall cycles", 32'(stallCycles), 32'd11);

        // Stray ack in IDLE with no request
        @(negedge clk_i);
        applyStimulus(1'b0, 1'b0, 32'h0000_0848, 32'h0);
        mem_data_i = '1;
        mem_ack_i  = 1'b1;
        #1;
        checkOutput("stray enable", {31'b0, mem_enable_o}, 32'd0);
        checkOutput("stray stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0000_0848, 32'h0);
        #1;
        checkOutput("stray after stall", {31'b0, stall_o}, 32'd0);
        checkOutput("stray after rdata", rdata_o, 32'hC000_0002);

        // Reset three cycles into a refill
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        #1;
        checkOutput("pre-reset miss stall", {31'b0, stall_o}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            #1;
        end
        checkOutput("mid fill enable", {31'b0, mem_enable_o}, 32'd1);
        checkOutput("mid fill addr", mem_addr_o, 32'h0000_0040);
        rst_i = 1'b0;
        #1;
        checkOutput("async reset enable", {31'b0, mem_enable_o}, 32'd0);
        checkOutput("async reset stall", {31'b0, stall_o}, 32'd0);
        checkOutput("async reset addr", mem_addr_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0000_0848, 32'h0);
        #1;
        checkOutput("post-reset miss stall", {31'b0, stall_o}, 32'd1);
        checkOutput("post-reset rdata", rdata_o, 32'h0);
        stallCycles = 1;
        memPhase("post-reset fill", 1'b0, 32'h0000_0840, lineC, 0, 32'h0);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        checkOutput("post-reset hit stall", {31'b0, stall_o}, 32'd0);
        checkOutput("post-reset hit rdata", rdata_o, 32'hC000_0002);
        checkOutput("post-reset stall cycles", 32'(stallCycles), 32'd11);

        @(negedge clk_i);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
